// File: rtl/mem_stage_hs.sv
// mem_stage_hs: memory-access stage of the 5-stage pipeline (between execute
// and writeback). It holds one instruction at a time, waits on a
// variable-latency data SRAM for loads, extracts sub-word load results and
// drives a forwarding port toward decode. Loads that are flushed while their
// request is still in flight are counted, so their late responses can be
// recognised and dropped.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   ws_allowin            writeback can take an instruction this cycle
//   ms_allowin            this stage can take an instruction this cycle
//   es_to_ms_valid, es_*  instruction from execute (pc, alu result/address,
//                         dest, write enable, load flag, load type)
//   ms_flush              kill the resident instruction
//   data_sram_data_ok/rdata  read response from the data SRAM
//   ms_to_ws_valid, ms_ws_*  completed instruction to writeback
//   ms_fwd_dest/data/pending forwarding info for decode
module mem_stage_hs #(
    parameter int DATA_W     = 32,
    parameter int DEST_W     = 5,
    parameter int MAX_CANCEL = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ws_allowin,
    output logic              ms_allowin,
    input  logic              es_to_ms_valid,
    input  logic [31:0]       es_pc,
    input  logic [DATA_W-1:0] es_alu_result,
    input  logic [DEST_W-1:0] es_dest,
    input  logic              es_gr_we,
    input  logic              es_load,
    input  logic [2:0]        es_ld_type,
    input  logic              ms_flush,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata,
    output logic              ms_to_ws_valid,
    output logic [31:0]       ms_ws_pc,
    output logic              ms_ws_gr_we,
    output logic [DEST_W-1:0] ms_ws_dest,
    output logic [DATA_W-1:0] ms_ws_result,
    output logic [DEST_W-1:0] ms_fwd_dest,
    output logic [DATA_W-1:0] ms_fwd_data,
    output logic              ms_fwd_pending
);
    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int CNT_W = $clog2(MAX_CANCEL + 1);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD, READY} state_t;

    typedef struct packed {
        logic [31:0]       pc;
        logic [DATA_W-1:0] alu;
        logic [DEST_W-1:0] dest;
        logic              gr_we;
        logic              load;
        logic [2:0]        ld_type;
    } ms_req_t;

    state_t            state_q, state_d;
    ms_req_t           req_q;
    logic [DATA_W-1:0] buf_q;
    logic [CNT_W-1:0]  discard_q, discard_d;

    logic ms_valid, got, in_wait;
    logic discard_hit, load_ok, ms_ready_go;

    assign ms_valid = (state_q != IDLE);
    assign got      = (state_q == HOLD);
    assign in_wait  = (state_q == WAIT);

    // A response goes to the discard counter first; only with the counter at
    // zero can it belong to the resident load.
    assign discard_hit = data_sram_data_ok && (discard_q != '0);
    assign load_ok     = in_wait && data_sram_data_ok && (discard_q == '0);

    assign ms_ready_go    = !req_q.load || got || (data_sram_data_ok && (discard_q == '0));
    assign ms_to_ws_valid = ms_valid && ms_ready_go && !ms_flush;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin) || ms_flush;

    // Next state
    always_comb begin
        state_d = state_q;
        if (ms_allowin) begin
            if (es_to_ms_valid) state_d = es_load ? WAIT : READY;
            else                state_d = IDLE;
        end else if (load_ok) begin
            // Data arrived but writeback is stalled: park it in the buffer.
            state_d = HOLD;
        end
    end

    // Discard counter. A flushed load in WAIT leaves a response outstanding
    // unless this cycle's data_ok was its own response. When a stale response
    // is dropped in the same cycle a waiting load is flushed, the two cancel.
    always_comb begin
        logic inc;
        inc       = ms_flush && in_wait && !load_ok;
        discard_d = discard_q;
        if (inc && !discard_hit) begin
            if (discard_q != CNT_W'(MAX_CANCEL)) discard_d = discard_q + 1'b1;
        end else if (discard_hit && !inc) begin
            discard_d = discard_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            req_q     <= '0;
            buf_q     <= '0;
            discard_q <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            if (es_to_ms_valid && ms_allowin) begin
                req_q.pc      <= es_pc;
                req_q.alu     <= es_alu_result;
                req_q.dest    <= es_dest;
                req_q.gr_we   <= es_gr_we;
                req_q.load    <= es_load;
                req_q.ld_type <= es_ld_type;
            end
            if (!ms_allowin && load_ok) buf_q <= data_sram_rdata;
        end
    end

    // Sub-word extraction. Buffered data once held, else the live bus so a
    // response with writeback ready passes straight through.
    logic [DATA_W-1:0] raw, ld_result, result;
    logic [OFF_W-1:0]  off;
    logic [7:0]        b;
    logic [15:0]       h;
    logic [31:0]       w;

    assign raw = got ? buf_q : data_sram_rdata;
    assign off = req_q.alu[OFF_W-1:0];

    always_comb begin
        b = 8'(raw >> {off, 3'b000});
        h = 16'(raw >> {off[OFF_W-1:1], 4'b0000});
        // Word select by the top offset bit; only meaningful for 64-bit data.
        w = 32'(raw >> {off[OFF_W-1], 5'b00000});
        case (req_q.ld_type)
            3'd1:    ld_result = DATA_W'(signed'(b));
            3'd2:    ld_result = DATA_W'(b);
            3'd3:    ld_result = DATA_W'(signed'(h));
            3'd4:    ld_result = DATA_W'(h);
            3'd5:    ld_result = (DATA_W == 64) ? DATA_W'(signed'(w)) : raw;
            default: ld_result = raw;
        endcase
        result = req_q.load ? ld_result : req_q.alu;
    end

    assign ms_ws_pc       = req_q.pc;
    assign ms_ws_gr_we    = req_q.gr_we;
    assign ms_ws_dest     = req_q.dest;
    assign ms_ws_result   = result;
    assign ms_fwd_dest    = (ms_valid && req_q.gr_we && !ms_flush) ? req_q.dest : '0;
    assign ms_fwd_data    = result;
    assign ms_fwd_pending = ms_valid && req_q.load && !ms_ready_go;

endmodule

// File: tb/tb_mem_stage_hs.sv
module tb_mem_stage_hs;
    logic        clk = 0;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [31:0] es_pc;
    logic [31:0] es_alu_result;
    logic [4:0]  es_dest;
    logic        es_gr_we;
    logic        es_load;
    logic [2:0]  es_ld_type;
    logic        ms_flush;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ms_to_ws_valid;
    logic [31:0] ms_ws_pc;
    logic        ms_ws_gr_we;
    logic [4:0]  ms_ws_dest;
    logic [31:0] ms_ws_result;
    logic [4:0]  ms_fwd_dest;
    logic [31:0] ms_fwd_data;
    logic        ms_fwd_pending;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage_hs #(.DATA_W(32), .DEST_W(5), .MAX_CANCEL(3)) dut (
        .clk(clk), .reset(reset), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
        .es_to_ms_valid(es_to_ms_valid), .es_pc(es_pc), .es_alu_result(es_alu_result),
        .es_dest(es_dest), .es_gr_we(es_gr_we), .es_load(es_load), .es_ld_type(es_ld_type),
        .ms_flush(ms_flush), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .ms_to_ws_valid(ms_to_ws_valid),
        .ms_ws_pc(ms_ws_pc), .ms_ws_gr_we(ms_ws_gr_we), .ms_ws_dest(ms_ws_dest),
        .ms_ws_result(ms_ws_result), .ms_fwd_dest(ms_fwd_dest), .ms_fwd_data(ms_fwd_data),
        .ms_fwd_pending(ms_fwd_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        load;
        logic [2:0]  ld_type;
        logic [31:0] addr;
        logic [31:0] rdata;
        int          delay;
        logic [4:0]  dest;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Move to just after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        es_to_ms_valid = 0; es_pc = 0; es_alu_result = 0; es_dest = 0;
        es_gr_we = 0; es_load = 0; es_ld_type = 0; ms_flush = 0;
        data_sram_data_ok = 0; data_sram_rdata = 0; ws_allowin = 1;
    endtask

    task automatic present(input logic [31:0] pc, input logic ld, input logic [2:0] t,
                           input logic [31:0] addr, input logic [4:0] dest);
        es_to_ms_valid = 1; es_pc = pc; es_load = ld; es_ld_type = t;
        es_alu_result = addr; es_dest = dest; es_gr_we = 1;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        present(32'h1000 + 32'(i * 4), v.load, v.ld_type, v.addr, v.dest);
        ws_allowin = 1;
        sample();
        chk($sformatf("v%0d_allowin", i), 32'(ms_allowin), 32'd1);
        step();
        es_to_ms_valid = 0;
        for (int d = 0; d < v.delay; d++) begin
            sample();
            chk($sformatf("v%0d_pending_c%0d", i, d), 32'(ms_fwd_pending), 32'd1);
            chk($sformatf("v%0d_novalid_c%0d", i, d), 32'(ms_to_ws_valid), 32'd0);
            step();
        end
        if (v.load) begin
            data_sram_data_ok = 1;
            data_sram_rdata = v.rdata;
        end
        sample();
        chk($sformatf("v%0d_valid", i), 32'(ms_to_ws_valid), 32'd1);
        chk($sformatf("v%0d_result", i), ms_ws_result, v.exp);
        chk($sformatf("v%0d_fwd_data", i), ms_fwd_data, v.exp);
        chk($sformatf("v%0d_fwd_dest", i), 32'(ms_fwd_dest), 32'(v.dest));
        chk($sformatf("v%0d_pending", i), 32'(ms_fwd_pending), 32'd0);
        chk($sformatf("v%0d_pc", i), ms_ws_pc, 32'h1000 + 32'(i * 4));
        step();
        data_sram_data_ok = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            load ty addr          rdata          dly dest exp
        vecs[0] = '{1'b0, 3'd0, 32'h0000_1234, 32'h0,         0, 5'd5, 32'h0000_1234};
        vecs[1] = '{1'b1, 3'd1, 32'h0000_1003, 32'h80FF_1234, 3, 5'd6, 32'hFFFF_FF80};
        vecs[2] = '{1'b1, 3'd2, 32'h0000_1003, 32'h80FF_1234, 3, 5'd6, 32'h0000_0080};
        vecs[3] = '{1'b1, 3'd3, 32'h0000_2002, 32'h8001_0000, 1, 5'd7, 32'hFFFF_8001};
        vecs[4] = '{1'b1, 3'd4, 32'h0000_2002, 32'h8001_0000, 0, 5'd7, 32'h0000_8001};
        vecs[5] = '{1'b1, 3'd0, 32'h0000_3001, 32'hCAFE_BABE, 2, 5'd8, 32'hCAFE_BABE};
        vecs[6] = '{1'b1, 3'd1, 32'h0000_0000, 32'h0000_007F, 0, 5'd9, 32'h0000_007F};
        vecs[7] = '{1'b1, 3'd3, 32'h0000_0003, 32'h7FFF_0000, 1, 5'd10, 32'h0000_7FFF};
        vecs[8] = '{1'b1, 3'd5, 32'h0000_0000, 32'h1234_5678, 0, 5'd11, 32'h1234_5678};

        idle_inputs();
        reset = 1;
        step(); step();
        reset = 0;
        sample();
        chk("rst_allowin", 32'(ms_allowin), 32'd1);
        chk("rst_valid", 32'(ms_to_ws_valid), 32'd0);
        chk("rst_result", ms_ws_result, 32'd0);
        chk("rst_pc", ms_ws_pc, 32'd0);
        chk("rst_fwd_dest", 32'(ms_fwd_dest), 32'd0);
        chk("rst_pending", 32'(ms_fwd_pending), 32'd0);
        step();

        for (int i = 0; i < 9; i++) run_vec(i);

        // Writeback stall when the load data arrives: buffered, then released.
        present(32'h2000, 1'b1, 3'd0, 32'h0000_4000, 5'd12);
        step();
        present(32'h2004, 1'b0, 3'd0, 32'h0000_0055, 5'd13);
        ws_allowin = 0;
        data_sram_data_ok = 1; data_sram_rdata = 32'hDEAD_BEEF;
        sample();
        chk("hold_c0_allowin", 32'(ms_allowin), 32'd0);
        chk("hold_c0_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("hold_c0_result", ms_ws_result, 32'hDEAD_BEEF);
        step();
        data_sram_data_ok = 0; data_sram_rdata = 32'h0BAD_F00D;
        sample();
        chk("hold_c1_allowin", 32'(ms_allowin), 32'd0);
        chk("hold_c1_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("hold_c1_result", ms_ws_result, 32'hDEAD_BEEF);
        chk("hold_c1_pending", 32'(ms_fwd_pending), 32'd0);
        step();
        ws_allowin = 1;
        sample();
        chk("hold_rel_result", ms_ws_result, 32'hDEAD_BEEF);
        chk("hold_rel_pc", ms_ws_pc, 32'h2000);
        chk("hold_rel_allowin", 32'(ms_allowin), 32'd1);
        step();
        es_to_ms_valid = 0;
        sample();
        chk("hold_next_pc", ms_ws_pc, 32'h2004);
        chk("hold_next_result", ms_ws_result, 32'h0000_0055);
        step();

        // Flush of a waiting load; its late response must be dropped.
        present(32'h3000, 1'b1, 3'd0, 32'h0000_5000, 5'd14);
        step();
        present(32'h3004, 1'b1, 3'd0, 32'h0000_5004, 5'd15);
        ms_flush = 1;
        sample();
        chk("fl_valid", 32'(ms_to_ws_valid), 32'd0);
        chk("fl_fwd_dest", 32'(ms_fwd_dest), 32'd0);
        chk("fl_allowin", 32'(ms_allowin), 32'd1);
        step();
        ms_flush = 0; es_to_ms_valid = 0;
        sample();
        chk("fl_discard1", 32'(dut.discard_q), 32'd1);
        chk("fl_pending_b", 32'(ms_fwd_pending), 32'd1);
        step();
        data_sram_data_ok = 1; data_sram_rdata = 32'h1111_1111;
        sample();
        chk("fl_stale_valid", 32'(ms_to_ws_valid), 32'd0);
        chk("fl_stale_pending", 32'(ms_fwd_pending), 32'd1);
        step();
        data_sram_rdata = 32'h2222_2222;
        sample();
        chk("fl_discard0", 32'(dut.discard_q), 32'd0);
        chk("fl_b_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("fl_b_result", ms_ws_result, 32'h2222_2222);
        chk("fl_b_pc", ms_ws_pc, 32'h3004);
        step();
        data_sram_data_ok = 0;

        // Two flushed loads outstanding, then reset while a third waits.
        present(32'h4000, 1'b1, 3'd0, 32'h0, 5'd16);
        step();
        present(32'h4004, 1'b1, 3'd0, 32'h0, 5'd17);
        ms_flush = 1;
        step();
        present(32'h4008, 1'b1, 3'd0, 32'h0, 5'd18);
        step();
        ms_flush = 0; es_to_ms_valid = 0;
        sample();
        chk("rs_discard2", 32'(dut.discard_q), 32'd2);
        chk("rs_pending", 32'(ms_fwd_pending), 32'd1);
        step();
        reset = 1;
        step();
        reset = 0;
        sample();
        chk("rs_allowin", 32'(ms_allowin), 32'd1);
        chk("rs_valid", 32'(ms_to_ws_valid), 32'd0);
        chk("rs_discard0", 32'(dut.discard_q), 32'd0);
        chk("rs_result", ms_ws_result, 32'd0);
        chk("rs_fwd_dest", 32'(ms_fwd_dest), 32'd0);
        chk("rs_pending", 32'(ms_fwd_pending), 32'd0);
        chk("rs_pc", ms_ws_pc, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
